// File: rtl/stepper_move_sequencer.sv
// Stepper move sequencer: runs a move of N steps at one step per `period` clocks, first step `period` clocks after accept.
// cmd_ready only while IDLE; abort and the direction-matching end-stop end a running move early.
module stepper_move_sequencer #(
  parameter int STEP_BITS   = 16,
  parameter int PERIOD_BITS = 16,
  parameter int POS_BITS    = 16
) (
  input  logic                   clock_clk,
  input  logic                   reset_reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [STEP_BITS-1:0]   cmd_steps,
  input  logic [PERIOD_BITS-1:0] cmd_period,
  input  logic                   abort,
  input  logic                   limit_fwd,
  input  logic                   limit_rev,
  input  logic                   hold_en,
  output logic [3:0]             coil,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [STEP_BITS-1:0]   steps_left,
  output logic [POS_BITS-1:0]    position
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                 state, state_nxt;
  logic                   dir_q, dir_nxt;
  logic [PERIOD_BITS-1:0] period_q, period_nxt;
  logic [PERIOD_BITS-1:0] cnt, cnt_nxt;
  logic [STEP_BITS-1:0]   steps_nxt;
  logic [POS_BITS-1:0]    pos_nxt;
  logic [1:0]             phase, phase_nxt;
  logic [1:0]             status_nxt;
  logic [3:0]             coil_nxt;
  logic                   run_limit_hit;
  logic                   cmd_limit_hit;

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state == RUN);
  assign done          = (state == FIN);
  assign run_limit_hit = dir_q ? limit_fwd : limit_rev;
  assign cmd_limit_hit = cmd_dir ? limit_fwd : limit_rev;

  always_comb begin
    state_nxt  = state;
    dir_nxt    = dir_q;
    period_nxt = period_q;
    cnt_nxt    = cnt;
    steps_nxt  = steps_left;
    pos_nxt    = position;
    phase_nxt  = phase;
    status_nxt = status;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_nxt    = cmd_dir;
          steps_nxt  = cmd_steps;
          // Period below 2 would make a step every cycle with no counting room.
          period_nxt = (cmd_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : cmd_period;
          cnt_nxt    = '0;
          if (cmd_steps == '0) begin
            state_nxt  = FIN;
            status_nxt = 2'b00;
          end else if (cmd_limit_hit) begin
            state_nxt  = FIN;
            status_nxt = 2'b10;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Abort outranks the end-stop, and both suppress a step due this cycle.
        if (abort) begin
          state_nxt  = FIN;
          status_nxt = 2'b01;
        end else if (run_limit_hit) begin
          state_nxt  = FIN;
          status_nxt = 2'b10;
        end else if (cnt == period_q - PERIOD_BITS'(1)) begin
          cnt_nxt   = '0;
          phase_nxt = dir_q ? phase + 2'd1 : phase - 2'd1;
          pos_nxt   = dir_q ? position + POS_BITS'(1) : position - POS_BITS'(1);
          steps_nxt = steps_left - STEP_BITS'(1);
          if (steps_left == STEP_BITS'(1)) begin
            state_nxt  = FIN;
            status_nxt = 2'b00;
          end
        end else begin
          cnt_nxt = cnt + PERIOD_BITS'(1);
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    coil_nxt = ((state_nxt != IDLE) || hold_en) ? (4'b0001 << phase_nxt) : 4'b0000;
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      period_q   <= PERIOD_BITS'(2);
      cnt        <= '0;
      steps_left <= '0;
      position   <= '0;
      phase      <= 2'd0;
      status     <= 2'b00;
      coil       <= 4'b0000;
    end else begin
      state      <= state_nxt;
      dir_q      <= dir_nxt;
      period_q   <= period_nxt;
      cnt        <= cnt_nxt;
      steps_left <= steps_nxt;
      position   <= pos_nxt;
      phase      <= phase_nxt;
      status     <= status_nxt;
      coil       <= coil_nxt;
    end
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer with hand-computed expectations.
module tb_stepper_move_sequencer;

  logic        clock_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        limit_fwd = 1'b0;
  logic        limit_rev = 1'b0;
  logic        hold_en = 1'b0;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [15:0] steps_left;
  logic [15:0] position;

  int tests = 0;
  int fails = 0;

  stepper_move_sequencer dut (
    .clock_clk(clock_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .limit_fwd(limit_fwd), .limit_rev(limit_rev), .hold_en(hold_en),
    .coil(coil), .busy(busy), .done(done), .status(status),
    .steps_left(steps_left), .position(position)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
  endtask

  task automatic accept(input logic d, input logic [15:0] s, input logic [15:0] p);
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = s; cmd_period = p;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tests++; if (coil !== 4'b0000) begin fails++; $display("FAIL rst_coil got %b exp 0000", coil); end
    tests++; if ({busy, done, status} !== 4'b0000) begin fails++; $display("FAIL rst_flags got %b exp 0000", {busy, done, status}); end
    tests++; if (position !== 16'h0 || steps_left !== 16'h0) begin fails++; $display("FAIL rst_counts got pos %h steps %h exp 0 0", position, steps_left); end
    reset_reset = 1'b0;
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_forward();
    do_reset();
    accept(1'b1, 16'd3, 16'd4);
    tests++; if ({busy, cmd_ready, coil} !== 6'b10_0001) begin fails++; $display("FAIL fwd_start got %b exp 100001", {busy, cmd_ready, coil}); end
    tick(3);
    tests++; if (coil !== 4'b0001 || position !== 16'd0) begin fails++; $display("FAIL fwd_pre_step got coil %b pos %0d exp 0001 0", coil, position); end
    tick();
    tests++; if (coil !== 4'b0010 || position !== 16'd1 || steps_left !== 16'd2) begin fails++; $display("FAIL fwd_step1 got coil %b pos %0d left %0d exp 0010 1 2", coil, position, steps_left); end
    tick(4);
    tests++; if (coil !== 4'b0100 || position !== 16'd2) begin fails++; $display("FAIL fwd_step2 got coil %b pos %0d exp 0100 2", coil, position); end
    tick(3);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL fwd_early_done got %b exp 0", done); end
    tick();
    tests++; if ({done, status, coil} !== 7'b1_00_1000 || position !== 16'd3) begin fails++; $display("FAIL fwd_finish got %b pos %0d exp 1001000 3", {done, status, coil}, position); end
    tick();
    tests++; if ({done, busy, cmd_ready, coil} !== 7'b001_0000) begin fails++; $display("FAIL fwd_idle got %b exp 0010000", {done, busy, cmd_ready, coil}); end
  endtask

  task automatic test_reverse_wrap();
    do_reset();
    accept(1'b0, 16'd2, 16'd2);
    tick(2);
    tests++; if (coil !== 4'b1000 || position !== 16'hFFFF) begin fails++; $display("FAIL rev_step1 got coil %b pos %h exp 1000 ffff", coil, position); end
    tick(2);
    tests++; if (coil !== 4'b0100 || position !== 16'hFFFE || {done, status} !== 3'b100) begin fails++; $display("FAIL rev_step2 got coil %b pos %h done/st %b exp 0100 fffe 100", coil, position, {done, status}); end
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    accept(1'b1, 16'd10, 16'd3);
    tick(12);
    tests++; if (steps_left !== 16'd6 || position !== 16'd4) begin fails++; $display("FAIL abort_pre got left %0d pos %0d exp 6 4", steps_left, position); end
    tick(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({done, status} !== 3'b101 || steps_left !== 16'd6 || position !== 16'd4) begin fails++; $display("FAIL abort_fin got done/st %b left %0d pos %0d exp 101 6 4", {done, status}, steps_left, position); end
    tests++; if (coil !== 4'b0001) begin fails++; $display("FAIL abort_coil got %b exp 0001", coil); end
    tick();
    tests++; if ({done, coil} !== 5'b0_0000) begin fails++; $display("FAIL abort_after got %b exp 00000", {done, coil}); end
  endtask

  task automatic test_limit();
    // Continues from the abort test: position 4, phase 0.
    limit_fwd = 1'b1;
    accept(1'b1, 16'd5, 16'd4);
    limit_fwd = 1'b0;
    tests++; if ({done, status} !== 3'b110 || position !== 16'd4) begin fails++; $display("FAIL lim_accept got done/st %b pos %0d exp 110 4", {done, status}, position); end
    tick();
    limit_rev = 1'b1;
    accept(1'b1, 16'd2, 16'd2);
    tick(4);
    limit_rev = 1'b0;
    tests++; if ({done, status} !== 3'b100 || position !== 16'd6) begin fails++; $display("FAIL lim_opposite got done/st %b pos %0d exp 100 6", {done, status}, position); end
    tick();
    accept(1'b1, 16'd3, 16'd2);
    tick(3);
    limit_fwd = 1'b1;
    tick();
    limit_fwd = 1'b0;
    tests++; if ({done, status} !== 3'b110 || steps_left !== 16'd2 || position !== 16'd7) begin fails++; $display("FAIL lim_run got done/st %b left %0d pos %0d exp 110 2 7", {done, status}, steps_left, position); end
    tick();
  endtask

  task automatic test_edges();
    accept(1'b1, 16'd0, 16'd5);
    tests++; if ({done, status, busy} !== 4'b1000) begin fails++; $display("FAIL zero_steps got %b exp 1000", {done, status, busy}); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_steps_pulse got %b exp 0", done); end
    do_reset();
    accept(1'b1, 16'd1, 16'd0);
    tick();
    tests++; if ({busy, done, coil} !== 6'b10_0001) begin fails++; $display("FAIL p0_half got %b exp 100001", {busy, done, coil}); end
    tick();
    tests++; if ({done, coil} !== 5'b1_0010 || position !== 16'd1) begin fails++; $display("FAIL p0_step got %b pos %0d exp 10010 1", {done, coil}, position); end
    hold_en = 1'b1;
    tick(3);
    tests++; if (coil !== 4'b0010) begin fails++; $display("FAIL hold_coil got %b exp 0010", coil); end
    hold_en = 1'b0;
    tick();
    tests++; if (coil !== 4'b0000) begin fails++; $display("FAIL hold_release got %b exp 0000", coil); end
  endtask

  task automatic test_async_reset();
    int seen_done;
    seen_done = 0;
    do_reset();
    accept(1'b1, 16'd5, 16'd2);
    tick(3);
    tests++; if (position !== 16'd1 || busy !== 1'b1) begin fails++; $display("FAIL arst_pre got pos %0d busy %b exp 1 1", position, busy); end
    #2 reset_reset = 1'b1;
    #1;
    tests++; if ({busy, done, status, coil} !== 8'h00 || position !== 16'd0 || steps_left !== 16'd0) begin fails++; $display("FAIL arst_async got %b pos %0d left %0d exp 0 0 0", {busy, done, status, coil}, position, steps_left); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got %b exp 1", cmd_ready); end
    tick();
    reset_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      tick();
    end
    tests++; if (seen_done !== 0) begin fails++; $display("FAIL arst_no_done got %0d exp 0", seen_done); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_abort();
    test_limit();
    test_edges();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
